traffic_phase_scheduler: RTL
============================

// Module: traffic_phase_scheduler
// PURPOSE
//  Demand-driven phase scheduler for one two-road intersection with a pedestrian crossing.
//  Arbitrates green time between the NS and EW approaches and an all-red pedestrian WALK phase.
//  Inputs are vehicle/pedestrian request lines; outputs are light codes for the signal heads.
//  Replaces fixed-time cycling: greens are bounded by a min/max, yellow and all-red are fixed.
// PARAMETERS
//  MIN_GREEN  5   cycles a green is held before conflicting demand can end it (>=1)
//  MAX_GREEN  15  cycles after which green always ends (>=MIN_GREEN)
//  YELLOW     2   yellow duration, cycles (>=1)
//  ALL_RED    1   all-red clearance duration, cycles (>=1)
//  WALK       4   pedestrian walk duration, cycles (>=1)
//  CW         5   timer width; every duration must be <= 2**CW
// PORTS
//  clk       in   1  clock, all state updates on rising edge
//  rst       in   1  synchronous reset, active-high
//  ns_req    in   1  vehicle demand on NS approach (level)
//  ew_req    in   1  vehicle demand on EW approach (level)
//  ped_req   in   1  pedestrian button (pulse or level)
//  ns_light  out  2  NS head: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN
//  ew_light  out  2  EW head, same encoding
//  walk      out  1  pedestrian WALK indication
//  ped_ack   out  1  one-cycle pulse on first WALK cycle
//  phase     out  3  current state code (below), for debug/monitor
// BEHAVIOUR
//  - States/codes: AR=0 (all red), NSG=1, NSY=2, EWG=3, EWY=4, PED=5. Codes 6,7 -> AR next cycle.
//  - Outputs are registered/Moore: AR,PED: R/R; NSG: G/R; NSY: Y/R; EWG: R/G; EWY: R/Y. walk=1 only in PED.
//  - timer counts cycles in current state; cleared to 0 on every state change. Duration N => exit when timer==N-1.
//  - last_road flag: 0=NS served last, 1=EW served last; updated on entry to NSG(0)/EWG(1).
//  - ped_pend: set the cycle after ped_req=1 sampled in any state except PED; cleared on entry to PED
//    (clear wins over simultaneous set). ped_req in PED is ignored.
//  - Transitions:
//    AR  after ALL_RED cycles: ped_pend -> PED; else last_road==1 -> NSG; else -> EWG.
//    NSG exit when timer>=MIN_GREEN-1 and (ew_req | ped_pend), or timer==MAX_GREEN-1 -> NSY.
//    EWG exit when timer>=MIN_GREEN-1 and (ns_req | ped_pend), or timer==MAX_GREEN-1 -> EWY.
//    NSY/EWY after YELLOW cycles -> AR.  PED after WALK cycles -> AR.
//  - Green never directly follows green and never skips yellow+all-red; PED always entered and left via AR.
//  - With no demand, roads alternate at MAX_GREEN (no rest-in-green).
//  - Roads strictly alternate: a PED phase does not change last_road, so the unserved road is next.
//  - ped_ack=1 exactly in the cycle state first equals PED (timer==0), else 0.
//  - Reset (any time, incl. mid-phase): state=AR, timer=0, last_road=1, ped_pend=0;
//    outputs ns_light=ew_light=RED, walk=0, ped_ack=0, phase=0. First green after reset is NS.
//  - Request inputs are assumed synchronous to clk; no internal synchronisers.
// TESTING
//  1 rst 1 cycle, no requests -> AR 1 cyc, NSG 15, NSY 2, AR 1, EWG 15, EWY 2, AR 1, NSG...; walk=0 throughout.
//  2 ew_req=1 held from reset -> NSG lasts exactly 5 cycles, then NSY 2, AR 1, EWG 15 (ns_req=0).
//  3 ped_req 1-cycle pulse at NSG timer=2, no vehicle req -> NSG ends at 5 cycles; NSY 2, AR 1,
//    PED 4 (walk=1, R/R, ped_ack=1 only first PED cycle), AR 1, then EWG.
//  4 ped_req held high continuously -> sequence NSG5,NSY,AR,PED,AR,EWG5,EWY,AR,PED,AR,NSG...; each road still served.
//  5 rst=1 at EWY timer=0 -> next cycle phase=0, lights R/R, walk=0; pending ped cleared; then NSG after AR.
//  6 ew_req asserted at NSG timer=14 -> NSY entered at timer 14 exit (same as MAX); no 16th green cycle.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven phase scheduler for a two-road intersection
// with an all-red pedestrian WALK phase.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 15,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 4,
  parameter int CW        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    AR  = 3'd0,
    NSG = 3'd1,
    NSY = 3'd2,
    EWG = 3'd3,
    EWY = 3'd4,
    PED = 3'd5
  } state_t;

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;

  localparam logic [CW-1:0] T_MING = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] T_MAXG = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] T_YEL  = CW'(YELLOW - 1);
  localparam logic [CW-1:0] T_AR   = CW'(ALL_RED - 1);
  localparam logic [CW-1:0] T_WALK = CW'(WALK - 1);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] timer;
  logic          last_road;
  logic          ped_pend;
  logic          chg;
  logic [1:0]    ns_n;
  logic [1:0]    ew_n;

  // Next-state selection; greens yield to conflicting demand after MIN
  always_comb begin
    nxt = AR;
    case (state)
      AR: begin
        if (timer != T_AR)  nxt = AR;
        else if (ped_pend)  nxt = PED;
        else if (last_road) nxt = NSG;
        else                nxt = EWG;
      end
      NSG: begin
        if ((timer >= T_MING && (ew_req || ped_pend)) ||
            timer == T_MAXG)
          nxt = NSY;
        else
          nxt = NSG;
      end
      EWG: begin
        if ((timer >= T_MING && (ns_req || ped_pend)) ||
            timer == T_MAXG)
          nxt = EWY;
        else
          nxt = EWG;
      end
      NSY: nxt = (timer == T_YEL) ? AR : NSY;
      EWY: nxt = (timer == T_YEL) ? AR : EWY;
      PED: nxt = (timer == T_WALK) ? AR : PED;
      default: nxt = AR;
    endcase
  end

  assign chg = (nxt != state);

  // Light codes for the state about to be entered
  always_comb begin
    ns_n = RED;
    ew_n = RED;
    case (nxt)
      NSG: ns_n = GRN;
      NSY: ns_n = YEL;
      EWG: ew_n = GRN;
      EWY: ew_n = YEL;
      default: begin
        ns_n = RED;
        ew_n = RED;
      end
    endcase
  end

  // State, timer, service history, pending walk and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= AR;
      timer     <= '0;
      last_road <= 1'b1;
      ped_pend  <= 1'b0;
      ns_light  <= RED;
      ew_light  <= RED;
      walk      <= 1'b0;
      ped_ack   <= 1'b0;
      phase     <= 3'd0;
    end else begin
      state <= nxt;
      timer <= chg ? '0 : timer + 1'b1;
      if (chg && nxt == NSG) last_road <= 1'b0;
      if (chg && nxt == EWG) last_road <= 1'b1;
      if (chg && nxt == PED)
        ped_pend <= 1'b0;
      else if (ped_req && state != PED)
        ped_pend <= 1'b1;
      ns_light <= ns_n;
      ew_light <= ew_n;
      walk     <= (nxt == PED);
      ped_ack  <= chg && (nxt == PED);
      phase    <= nxt;
    end
  end

endmodule
